// File: rtl/mem_rr_arbiter_if.sv
// Bundle of the per-core picorv32 request ports and the shared memory bus.
// master: the arbiter's view; slave: the cores plus the downstream memory decoder.
interface mem_rr_arbiter_if #(
   parameter int unsigned N_CORES = 2
);
   logic [N_CORES-1:0]    req_valid;
   logic [32*N_CORES-1:0] req_addr;
   logic [32*N_CORES-1:0] req_wdata;
   logic [4*N_CORES-1:0]  req_wstrb;
   logic [N_CORES-1:0]    req_ready;
   logic [32*N_CORES-1:0] req_rdata;
   logic                  mem_valid;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_wstrb;
   logic                  mem_ready;
   logic [31:0]           mem_rdata;

   modport master (
      input  req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
      output req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
      input  req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory bus among N_CORES cores.
// Define ARB_TIMEOUT_EN to complete a stalled transaction with bus_error after TIMEOUT_CYCLES.
module mem_rr_arbiter #(
   parameter int unsigned N_CORES        = 2,
   parameter int unsigned IDX_BITS       = 1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                resetn,
   mem_rr_arbiter_if.master    bus,
   output logic [IDX_BITS-1:0] grant_idx,
   output logic                bus_error
);

   if (IDX_BITS != ((N_CORES > 1) ? $clog2(N_CORES) : 1)) begin : g_bad_idx_bits
      $error("IDX_BITS must equal max(1, clog2(N_CORES))");
   end
   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit the 8-bit counter and be nonzero");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e                state_q, state_d;
   logic [IDX_BITS-1:0]   prio_q, prio_d;
   logic [IDX_BITS-1:0]   grant_q, grant_d;
   logic [IDX_BITS-1:0]   win;
   logic                  found;
   int unsigned           idx;
   logic                  mem_valid_q, mem_valid_d;
   logic [31:0]           mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_wstrb_q, mem_wstrb_d;
   logic [N_CORES-1:0]    ready_q, ready_d;
   logic [32*N_CORES-1:0] rdata_q, rdata_d;
   logic                  done;
   logic [31:0]           resp_data;

   // First requester at or after prio_q, wrapping modulo N_CORES.
   always_comb begin
      found = 1'b0;
      win   = prio_q;
      idx   = 0;
      for (int k = 0; k < int'(N_CORES); k++) begin
         idx = (int'(prio_q) + k) % N_CORES;
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            win   = IDX_BITS'(idx);
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       timed_out;
   logic       err_q;

   // A mem_ready in the timeout cycle takes precedence over the timeout.
   always_comb begin
      done      = bus.mem_ready;
      resp_data = bus.mem_rdata;
      timed_out = 1'b0;
      cnt_d     = '0;
      if (state_q == StBusy && !bus.mem_ready) begin
         if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            done      = 1'b1;
            timed_out = 1'b1;
            resp_data = '0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= timed_out;
      end
   end

   assign bus_error = err_q;
`else
   always_comb begin
      done      = bus.mem_ready;
      resp_data = bus.mem_rdata;
   end

   assign bus_error = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      grant_d     = grant_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      ready_d     = '0;
      rdata_d     = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               mem_valid_d = 1'b1;
               mem_addr_d  = bus.req_addr[32*win +: 32];
               mem_wdata_d = bus.req_wdata[32*win +: 32];
               mem_wstrb_d = bus.req_wstrb[4*win +: 4];
               grant_d     = win;
               state_d     = StBusy;
            end
         end
         StBusy: begin
            if (done) begin
               mem_valid_d                = 1'b0;
               rdata_d[32*grant_q +: 32]  = resp_data;
               ready_d[grant_q]           = 1'b1;
               prio_d = (int'(grant_q) == int'(N_CORES) - 1) ? '0 : grant_q + 1'b1;
               state_d                    = StResp;
            end
         end
         // Served core still shows req_valid here, so no arbitration this cycle.
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         prio_q      <= '0;
         grant_q     <= '0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         ready_q     <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         grant_q     <= grant_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign bus.req_ready = ready_q;
   assign bus.req_rdata = rdata_q;
   assign grant_idx     = grant_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: cores and slave are driven on negedges, the
// expected completion order is queued by the stimulus and checked at each req_ready pulse.
module tb_mem_rr_arbiter;
   localparam int NC = 2;

   typedef struct {
      int          core;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        err;
      logic [31:0] rdata;
   } txn_t;

   logic       clk;
   logic       resetn;
   logic [0:0] grant_idx;
   logic       bus_error;

   mem_rr_arbiter_if #(.N_CORES(NC)) bus ();

   mem_rr_arbiter #(
      .N_CORES       (NC),
      .IDX_BITS      (1),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .bus      (bus),
      .grant_idx(grant_idx),
      .bus_error(bus_error)
   );

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          last_pulse = -1;
   txn_t        jobs [NC][$];
   txn_t        exp_q[$];
   logic [31:0] model [NC];
   int          slave_lat = 0;
   logic        slave_hang = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return a ^ 32'hCAFE_0011;
   endfunction

   task automatic issue(input int core, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
      txn_t t;
      t.core = core; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
      t.err = 1'b0; t.rdata = '0;
      jobs[core].push_back(t);
   endtask

   task automatic expect_txn(input int core, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic err);
      txn_t t;
      t.core = core; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
      t.err = err; t.rdata = err ? 32'h0 : rdata_of(addr);
      exp_q.push_back(t);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      repeat (3) @(posedge clk);
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      exp_q.delete();
      for (int i = 0; i < NC; i++) model[i] = '0;
      last_pulse = -1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_valid", bus.mem_valid, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_mem_wstrb", bus.mem_wstrb, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rdata0", bus.req_rdata[31:0], 0);
      check("rst_rdata1", bus.req_rdata[63:32], 0);
      check("rst_grant_idx", grant_idx, 0);
      check("rst_bus_error", bus_error, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
   endtask

   // Core model: holds each request until its req_ready, then loads the next job at once.
   initial begin
      logic [NC-1:0] v;
      txn_t          j;
      v = '0;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NC; i++) begin
            if (bus.req_ready[i]) v[i] = 1'b0;
            if (!v[i] && jobs[i].size() > 0) begin
               j = jobs[i].pop_front();
               bus.req_addr[32*i +: 32] = j.addr;
               bus.req_wdata[32*i +: 32] = j.wdata;
               bus.req_wstrb[4*i +: 4] = j.wstrb;
               v[i] = 1'b1;
            end
         end
         bus.req_valid = v;
      end
   end

   // Slave model: answers after slave_lat waiting cycles; checks the presented request each cycle.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_ready = 1'b0;
         if (bus.mem_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_mem_valid", 1, 0);
            end else begin
               check("mem_addr", bus.mem_addr, exp_q[0].addr);
               check("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
               check("mem_wstrb", bus.mem_wstrb, exp_q[0].wstrb);
            end
            if (!slave_hang) begin
               if (wait_cnt == slave_lat) begin
                  bus.mem_ready = 1'b1;
                  bus.mem_rdata = rdata_of(bus.mem_addr);
                  wait_cnt = 0;
               end else begin
                  wait_cnt++;
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Completion monitor.
   initial begin
      txn_t e;
      forever begin
         @(negedge clk);
         if (bus.req_ready != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_req_ready", 32'(bus.req_ready), 0);
            end else begin
               e = exp_q.pop_front();
               model[e.core] = e.rdata;
               check("req_ready_onehot", 32'(bus.req_ready), 32'(1 << e.core));
               check("grant_idx", 32'(grant_idx), 32'(e.core));
               check("resp_rdata0", bus.req_rdata[31:0], model[0]);
               check("resp_rdata1", bus.req_rdata[63:32], model[1]);
               check("bus_error", 32'(bus_error), 32'(e.err));
               check("mem_valid_in_resp", 32'(bus.mem_valid), 0);
               if (last_pulse >= 0) check("ready_gap_ge3", 32'(cyc - last_pulse >= 3), 1);
               last_pulse = cyc;
            end
         end else if (bus_error) begin
            check("stray_bus_error", 1, 0);
         end
      end
   end

   initial begin
      int n;
      int busy;
      resetn = 1'b0;
      apply_reset();

      // Single read by core 0, slave answers in the first busy cycle.
      slave_lat = 0;
      issue(0, 32'h0000_0010, 32'h0, 4'h0);
      expect_txn(0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      #1;
      check("req_valid0_up", 32'(bus.req_valid), 1);
      check("mem_valid_not_yet", 32'(bus.mem_valid), 0);
      @(negedge clk);
      check("mem_valid_rise", 32'(bus.mem_valid), 1);
      wait_drain(50);
      check("rdata0_cafe", bus.req_rdata[31:0], 32'hCAFE_0001);

      // Simultaneous requests from a fresh reset: core 0 then core 1.
      apply_reset();
      @(posedge clk);
      issue(0, 32'h0000_0020, 32'h0, 4'h0);
      issue(1, 32'h0000_0300, 32'h55AA_1234, 4'b1100);
      expect_txn(0, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
      expect_txn(1, 32'h0000_0300, 32'h55AA_1234, 4'b1100, 1'b0);
      wait_drain(50);

      // Continuous requests from both cores: grants alternate 0,1,0,1,...
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         issue(0, 32'h0000_0100 + 32'(k * 4), 32'h1111_0000 + 32'(k), 4'(k));
         issue(1, 32'h0000_0200 + 32'(k * 4), 32'h2222_0000 + 32'(k), 4'hF);
      end
      for (int k = 0; k < 4; k++) begin
         expect_txn(0, 32'h0000_0100 + 32'(k * 4), 32'h1111_0000 + 32'(k), 4'(k), 1'b0);
         expect_txn(1, 32'h0000_0200 + 32'(k * 4), 32'h2222_0000 + 32'(k), 4'hF, 1'b0);
      end
      wait_drain(200);

      // Byte write from core 1 with a slow slave; request must stay stable throughout.
      slave_lat = 5;
      @(posedge clk);
      issue(1, 32'h1000_0000, 32'h0000_0001, 4'b0001);
      expect_txn(1, 32'h1000_0000, 32'h0000_0001, 4'b0001, 1'b0);
      wait_drain(50);
      slave_lat = 1;

      // Core 0 read moves priority to core 1 before the reset test.
      @(posedge clk);
      issue(0, 32'h0000_0030, 32'h0, 4'h0);
      expect_txn(0, 32'h0000_0030, 32'h0, 4'h0, 1'b0);
      wait_drain(50);

      // Reset while core 1 is in flight: immediate abort, then core 0 wins the rerun.
      slave_hang = 1'b1;
      @(posedge clk);
      issue(1, 32'h2000_0040, 32'h0, 4'h0);
      expect_txn(1, 32'h2000_0040, 32'h0, 4'h0, 1'b0);
      n = 0;
      while (!bus.mem_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("hang_granted", 32'(bus.mem_valid), 1);
      repeat (3) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("async_mem_valid", 32'(bus.mem_valid), 0);
      check("async_req_ready", 32'(bus.req_ready), 0);
      check("async_grant_idx", 32'(grant_idx), 0);
      exp_q.delete();
      for (int i = 0; i < NC; i++) model[i] = '0;
      slave_hang = 1'b0;
      issue(0, 32'h0000_0050, 32'h0, 4'h0);
      repeat (2) @(negedge clk);
      check("rst_hold_req_ready", 32'(bus.req_ready), 0);
      expect_txn(0, 32'h0000_0050, 32'h0, 4'h0, 1'b0);
      expect_txn(1, 32'h2000_0040, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      #1;
      resetn = 1'b1;
      wait_drain(80);

`ifdef ARB_TIMEOUT_EN
      // Slave never answers: completes after 16 busy cycles with bus_error and rdata 0.
      slave_hang = 1'b1;
      @(posedge clk);
      issue(0, 32'h0000_0040, 32'h0, 4'h0);
      expect_txn(0, 32'h0000_0040, 32'h0, 4'h0, 1'b1);
      n = 0;
      while (!bus.mem_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      busy = 0;
      while (bus.mem_valid && busy < 40) begin
         busy++;
         @(negedge clk);
      end
      check("timeout_busy_cycles", 32'(busy), 16);
      wait_drain(50);

      // mem_ready in the timeout cycle itself: normal completion, no bus_error.
      slave_hang = 1'b0;
      slave_lat = 15;
      @(posedge clk);
      issue(1, 32'h0000_0044, 32'h0, 4'h0);
      expect_txn(1, 32'h0000_0044, 32'h0, 4'h0, 1'b0);
      n = 0;
      while (!bus.mem_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      busy = 0;
      while (bus.mem_valid && busy < 40) begin
         busy++;
         @(negedge clk);
      end
      check("late_ready_busy_cycles", 32'(busy), 16);
      wait_drain(50);
`else
      busy = 0;
      n = 0;
      check("bus_error_tied", 32'(bus_error), 32'(busy + n));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port memory/IO bus between N_CORES picorv32 native memory interfaces (valid/ready handshake).
- Sits between the cores and the SoC memory/peripheral decoder.
- Replaces free-running counter arbitration with request-driven, fair, one-transaction-at-a-time granting.
- Registers the selected request onto the shared bus, waits for the slave's ready, then returns rdata/ready to the granted core only.

Parameters:
- N_CORES, 2, number of requesting cores (2..4).
- IDX_BITS, 1, grant index width; must equal max(1, $clog2(N_CORES)).
- TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ready (used only with ARB_TIMEOUT_EN); 8-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  N_CORES  per-core request; held until that core's req_ready.
- req_addr  in  32*N_CORES  per-core byte address; core i at [32*i+31 -: 32].
- req_wdata  in  32*N_CORES  per-core write data.
- req_wstrb  in  4*N_CORES  per-core byte strobes; 0 means read.
- req_ready  out  N_CORES  one-cycle completion pulse to the granted core.
- req_rdata  out  32*N_CORES  per-core read data; valid while that core's req_ready is high.
- mem_valid  out  1  shared-bus request.
- mem_addr  out  32  shared-bus address.
- mem_wdata  out  32  shared-bus write data.
- mem_wstrb  out  4  shared-bus strobes.
- mem_ready  in  1  slave completion, may arrive 1..n cycles after mem_valid.
- mem_rdata  in  32  slave read data, valid with mem_ready.
- grant_idx  out  IDX_BITS  index of the current or last granted core (debug).
- bus_error  out  1  one-cycle pulse on timeout; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (resetn low, asynchronous):
  - State = IDLE; prio_ptr = 0; grant_idx = 0.
  - mem_valid = 0; mem_addr, mem_wdata and mem_wstrb = 0.
  - req_ready = 0; all req_rdata = 0; bus_error = 0; timeout counter = 0.
- States are IDLE, BUSY and RESP.
- IDLE:
  - If any req_valid is high, grant the first requester found scanning prio_ptr, prio_ptr+1, ... (mod N_CORES).
  - Register the granted core's addr/wdata/wstrb onto the mem_* outputs, set mem_valid = 1, set grant_idx = winner, and go to BUSY.
  - If no request is pending, stay in IDLE.
- BUSY:
  - Hold mem_* stable with mem_valid = 1.
  - On mem_ready = 1:
    - mem_valid <= 0.
    - req_rdata slice for grant_idx <= mem_rdata; this happens on writes too.
    - req_ready[grant_idx] <= 1.
    - prio_ptr <= (grant_idx + 1) mod N_CORES.
    - Go to RESP.
- RESP:
  - req_ready is high for exactly this cycle, then cleared.
  - Go to IDLE unconditionally; no arbitration is done in this cycle.
  - This matters because the served core still shows req_valid in this cycle.
- Latency:
  - Request seen in IDLE at cycle t gives mem_valid at t+1.
  - mem_ready at cycle t+k gives req_ready at t+k+1.
  - The next grant is possible at t+k+2.
  - Minimum occupancy per transaction is 3 cycles.
- Only the granted core's req_ready ever pulses; the rdata slices of the other cores hold their last values.
- Fairness: with all cores requesting continuously, grants rotate 0, 1, ..., N_CORES-1, 0, ...
- A request that is withdrawn while not granted is ignored.
- A request that is withdrawn while granted is a protocol violation. The transaction still completes and req_ready still pulses.
- A mem_ready received in IDLE or RESP is ignored.
- Asserting resetn low mid-transaction aborts immediately; no req_ready is issued.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle that has no mem_ready.
  - When the counter reaches TIMEOUT_CYCLES:
    - Complete the transaction as if mem_ready had arrived, with req_rdata slice = 32'h0000_0000.
    - bus_error pulses for 1 cycle, aligned with req_ready.
    - Rotate prio_ptr normally.
  - A mem_ready that arrives in the same cycle as the timeout wins: normal completion, no bus_error.
- ARB_TIMEOUT_EN undefined:
  - No counter is built; BUSY waits indefinitely.
  - bus_error is tied to 0.

Test Plan:
- Reset while idle, with core 0 reading 0x0000_0010 and slave ready 1 cycle later with rdata 0xCAFE_0001 -> mem_valid rises 1 cycle after req_valid; req_ready[0] pulses 1 cycle with rdata 0xCAFE_0001; req_ready[1] stays 0.
- Both cores request in the same cycle after reset -> core 0 granted first, then core 1; core 1's mem_addr/wstrb are presented unchanged; req_ready pulses are separated by ≥3 cycles.
- Both cores request continuously for 8 transactions -> grant_idx sequence 0,1,0,1,0,1,0,1.
- Core 1 writes 0x1000_0000 with wstrb 4'b0001 and wdata 0x01, while the slave delays mem_ready by 5 cycles -> mem_* stays stable for all 5 cycles; exactly one req_ready[1] pulse.
- resetn driven low during BUSY -> mem_valid drops asynchronously; no req_ready; after release, core 0 has priority.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_ready is never asserted -> after 16 BUSY cycles, req_ready and bus_error pulse together with rdata 0. Repeat with mem_ready arriving on cycle 16 -> bus_error stays 0.
